// File: rtl/serial_deserializer_fsm_pkg.sv
// rtl/serial_deserializer_fsm_pkg.sv - shared types and defaults for the serial deserializer
package serial_deserializer_fsm_pkg;

  localparam int DEFAULT_LENGTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_deserializer_fsm.sv
// rtl/serial_deserializer_fsm.sv - LSB-first serial to LENGTH-bit parallel converter with valid/ready hand-off
module serial_deserializer_fsm
  import serial_deserializer_fsm_pkg::*;
#(
  parameter int LENGTH = DEFAULT_LENGTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  input  logic              i_ready,
  output logic              o_ready,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid
);

  localparam int CW = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);

  state_t            state;
  logic [CW-1:0]     bit_cnt;
  logic [LENGTH-1:0] shreg;
  logic [LENGTH-1:0] dout_q;
  logic              valid_q;
  logic [LENGTH-1:0] shreg_next;

  // New bits enter at the MSB so that after LENGTH shifts the first bit sits at bit 0.
  assign shreg_next = {i_din, shreg[LENGTH-1:1]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else if (i_en) begin
      case (state)
        IDLE: begin
          if (i_din_valid) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (i_din_valid) begin
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == LAST_IDX) begin
              dout_q  <= shreg_next;
              valid_q <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          // Output word is left in place after hand-off; only the valid flag drops.
          if (i_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign o_ready      = (state == IDLE) && i_en && !i_rst;
  assign ov_dout      = dout_q;
  assign o_dout_valid = valid_q;

endmodule

// File: tb/tb_serial_deserializer_fsm.sv
// tb/tb_serial_deserializer_fsm.sv - self-checking bench for serial_deserializer_fsm
module tb_serial_deserializer_fsm;

  localparam int W = 24;

  logic         tb_clk;
  logic         rst;
  logic         en;
  logic         din;
  logic         din_valid;
  logic         ready;
  logic         blk_ready;
  logic [W-1:0] dout;
  logic         dout_valid;

  int checks;
  int failures;

  serial_deserializer_fsm #(.LENGTH(W)) dut (
    .i_clk        (tb_clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_din        (din),
    .i_din_valid  (din_valid),
    .i_ready      (ready),
    .o_ready      (blk_ready),
    .ov_dout      (dout),
    .o_dout_valid (dout_valid)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // stall_kind: 0 none, 1 drop din_valid, 2 drop en
  typedef struct {
    logic [W-1:0] word;
    int           stall_after;
    int           stall_kind;
    int           stall_len;
    int           bp_cycles;
    int           exp_edges;
  } vec_t;

  // Drives one frame; the expected word is rebuilt from the bits sent, the expected
  // edge count is start edge + W captures + stall edges.
  task automatic run_frame(input logic [W-1:0] word, input int stall_after, input int stall_kind,
                           input int stall_len, input int bp_cycles, input int exp_edges,
                           input string tag);
    int           edges;
    int           first_valid;
    logic [W-1:0] model;
    bit           bp_ok;
    model       = '0;
    first_valid = 0;
    @(negedge tb_clk);
    en = 1'b1; din_valid = 1'b1; din = 1'($urandom); ready = 1'b0;
    @(posedge tb_clk);
    edges = 1;
    for (int k = 0; k < W; k++) begin
      @(negedge tb_clk);
      if (dout_valid && first_valid == 0) first_valid = edges;
      en = 1'b1; din_valid = 1'b1; din = word[k];
      model = model + (W'(din) << k);
      @(posedge tb_clk);
      edges++;
      if (k == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge tb_clk);
          if (dout_valid && first_valid == 0) first_valid = edges;
          din = 1'($urandom);
          if (stall_kind == 1) din_valid = 1'b0;
          else begin en = 1'b0; din_valid = 1'($urandom); end
          @(posedge tb_clk);
          edges++;
        end
      end
    end
    @(negedge tb_clk);
    if (dout_valid && first_valid == 0) first_valid = edges;
    check({tag, "_latency"}, 32'(first_valid), 32'(exp_edges));
    check({tag, "_word"}, 32'(dout), 32'(model));
    bp_ok = 1'b1;
    for (int c = 0; c < bp_cycles; c++) begin
      din = 1'($urandom); din_valid = 1'($urandom); ready = 1'b0; en = 1'b1;
      @(negedge tb_clk);
      if (dout !== model || dout_valid !== 1'b1 || blk_ready !== 1'b0) bp_ok = 1'b0;
    end
    if (bp_cycles > 0) check({tag, "_backpressure"}, 32'(bp_ok), 32'd1);
    din_valid = 1'b0; ready = 1'b1; en = 1'b1;
    @(negedge tb_clk);
    ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(dout_valid), 32'd0);
    check({tag, "_word_kept"}, 32'(dout), 32'(model));
    check({tag, "_ready_idle"}, 32'(blk_ready), 32'd1);
  endtask

  task automatic idle_gap(input int n, input string tag);
    bit ok;
    ok = 1'b1;
    for (int c = 0; c < n; c++) begin
      en = 1'b1; din_valid = 1'b0; din = 1'($urandom); ready = 1'($urandom);
      @(negedge tb_clk);
      if (blk_ready !== 1'b1 || dout_valid !== 1'b0) ok = 1'b0;
    end
    ready = 1'b0;
    check({tag, "_idle_gap"}, 32'(ok), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b1; din = 1'b0; din_valid = 1'b0; ready = 1'b0;

    vecs[0] = '{word: 24'hFF00FF, stall_after: -1, stall_kind: 0, stall_len: 0, bp_cycles: 0,  exp_edges: 25};
    vecs[1] = '{word: 24'h00FF00, stall_after: -1, stall_kind: 0, stall_len: 0, bp_cycles: 0,  exp_edges: 25};
    vecs[2] = '{word: 24'hAF5EB9, stall_after: -1, stall_kind: 0, stall_len: 0, bp_cycles: 0,  exp_edges: 25};
    vecs[3] = '{word: 24'h5A3C96, stall_after: 10, stall_kind: 1, stall_len: 3, bp_cycles: 0,  exp_edges: 28};
    vecs[4] = '{word: 24'hC3E187, stall_after: 10, stall_kind: 2, stall_len: 3, bp_cycles: 0,  exp_edges: 28};
    vecs[5] = '{word: 24'h9E1B7D, stall_after: -1, stall_kind: 0, stall_len: 0, bp_cycles: 20, exp_edges: 25};

    repeat (2) @(negedge tb_clk);
    check("reset_ready", 32'(blk_ready), 32'd0);
    check("reset_valid", 32'(dout_valid), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    @(negedge tb_clk);
    check("post_reset_ready", 32'(blk_ready), 32'd1);
    en = 1'b0;
    #1;
    check("en_low_ready", 32'(blk_ready), 32'd0);
    en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].word, vecs[i].stall_after, vecs[i].stall_kind, vecs[i].stall_len,
                vecs[i].bp_cycles, vecs[i].exp_edges, $sformatf("vec%0d", i));
      idle_gap(3, $sformatf("vec%0d", i));
    end

    // Reset 12 bits into a frame while the previous word is still on ov_dout.
    @(negedge tb_clk);
    en = 1'b1; din_valid = 1'b1;
    @(posedge tb_clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge tb_clk);
      din = 1'($urandom);
      @(posedge tb_clk);
    end
    @(negedge tb_clk);
    din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_valid", 32'(dout_valid), 32'd0);
    check("midrst_ready", 32'(blk_ready), 32'd0);
    @(negedge tb_clk);
    rst = 1'b0;
    @(negedge tb_clk);
    check("midrst_idle_ready", 32'(blk_ready), 32'd1);
    run_frame(24'h123456, -1, 0, 0, 0, 25, "after_rst");
    idle_gap(5, "after_rst");

    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] w;
      int sl, sa, sk;
      w  = W'($urandom);
      sl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      sa = $urandom_range(0, W - 2);
      sk = $urandom_range(1, 2);
      run_frame(w, sa, sk, sl, $urandom_range(0, 4), 1 + W + sl, $sformatf("rnd%0d", i));
      idle_gap(50, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
